keypad_scanner: RTL
===================

# keypad_scanner

Parametrised matrix-keypad scanner: drives an active-low one-cold row strobe, samples active-low columns through a 2-flop synchroniser, debounces whole scan frames, and reports key press/release events with a binary key index. It replaces the fixed 4x4 decoder in front of the stopwatch/calculator control logic. Downstream logic consumes `key_press` and `key_release` pulses and the held `key_code`.

## Interface
- `ROWS`, 4, number of row lines driven (2..8)
- `COLS`, 4, number of column lines sampled (2..8)
- `SCAN_TICKS`, 12500, clk cycles each row is driven (>= 4); frame = ROWS*SCAN_TICKS
- `DB_FRAMES`, 10, consecutive identical frames required to accept a press or a release (>= 1)
- `REPEAT_DELAY`, 500, frames before first auto-repeat (used only with KEYPAD_REPEAT_EN)
- `REPEAT_RATE`, 100, frames between auto-repeats (used only with KEYPAD_REPEAT_EN)
- `clk` in 1: system clock; one clock domain
- `rst` in 1: synchronous, active-high reset
- `row` out ROWS: active-low row strobe, exactly one bit low at all times
- `col` in COLS: active-low column inputs, asynchronous, external pull-ups
- `key_code` out CODE_W = $clog2(ROWS*COLS): index row*COLS+col of accepted key
- `key_valid` out 1: high while a debounced key is held
- `key_press` out 1: one-cycle pulse on accepted press
- `key_release` out 1: one-cycle pulse on accepted release

## Operation
- Scan: tick counter 0..SCAN_TICKS-1; row index advances 0..ROWS-1 and wraps when the tick counter wraps; `row` = ~(1 << row index), registered.
- Sampling: synchronised `col` sampled on tick SCAN_TICKS-1 of each row period; key (r,c) is pressed when sync col[c]==0 while row r is low.
- Frame candidate: lowest-index pressed key over the frame (row-major priority); NONE when none pressed. Evaluated on the last tick of row ROWS-1.
- Debounce: a frame counter increments when the candidate equals the previous frame's, else reloads to 1; it saturates at DB_FRAMES. The candidate is stable when the counter reaches DB_FRAMES.
- FSM, states IDLE and HELD:
  - IDLE + stable key K: `key_code`<=K, `key_valid`<=1, `key_press` pulse, go to HELD.
  - HELD + stable NONE: `key_release` pulse, `key_valid`<=0, `key_code` holds, go to IDLE.
  - HELD + stable key J != `key_code`: `key_release` pulse in cycle N; in cycle N+1 `key_code`<=J and `key_press` pulse; stays HELD, `key_valid` stays high.
  - HELD + stable same key: no event (see Configuration).
- Each transition fires once per stable run; the counter does not retrigger while saturated at the same candidate.
- Ghosting is not resolved; multi-key presses report the lowest index only.

## Timing
- Reset values: `row` = ~1 (row 0 low), `key_code` = 0, `key_valid` = 0, `key_press` = 0, `key_release` = 0; counters 0, FSM IDLE, previous candidate NONE, synchroniser flops all ones.
- `rst` mid-operation returns everything to reset values on the next edge; a held key is re-accepted only after DB_FRAMES full frames and is reported as a fresh press.
- Column-to-sample latency: 2 cycles of synchroniser; the sample point at tick SCAN_TICKS-1 guarantees >= 2 settled cycles.
- Press latency: `key_press` asserts in the cycle after the closing sample of the DB_FRAMES-th identical frame; `key_code`/`key_valid` update in the same cycle as the pulse.
- Pulses are exactly one cycle wide; `key_press` and `key_release` are never high in the same cycle.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in HELD with the same stable key, `key_press` re-pulses after REPEAT_DELAY further frames, then every REPEAT_RATE frames until release or key change; any change or reset clears the repeat counter.
- Not defined: REPEAT_* ignored, no repeat logic; exactly one `key_press` per accepted press.

## Test plan
- Reset: assert `rst` 3 cycles -> `row`=4'b1110, all outputs 0; `row` rotates 1110,1101,1011,0111 every SCAN_TICKS cycles.
- Single key row 2 col 1 (4x4) held 20 frames -> one `key_press` after frame 10, `key_code`=9, `key_valid`=1; release -> `key_release` after 10 NONE frames, `key_code` stays 9.
- Bounce: toggle key 6 every 3 frames for 30 frames -> no `key_press`, `key_valid`=0.
- Keys 5 and 10 both held -> `key_code`=5; release 5, keep 10 -> `key_release` then next cycle `key_press` with `key_code`=10.
- `rst` pulsed while key 3 held -> outputs clear; `key_press` with code 3 again 10 frames later.
- KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, key 0 held 20 frames -> presses at frames 10, 15, 17, 19.

Source files
------------

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Matrix-keypad scanner. Drives one row low at a time and samples the
// active-low columns through a two-flop synchroniser. A candidate key is formed
// for every full scan frame, and the candidate is debounced across whole frames.
// Accepted presses and releases are reported as single-cycle pulses, together
// with a held binary key index.
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat of key_press
// while the same key stays held (REPEAT_DELAY frames first, then every
// REPEAT_RATE frames). When the macro is undefined, the REPEAT_* parameters are
// ignored.
//
// Ports:
//   clk          system clock (single domain)
//   rst          synchronous, active-high reset
//   row          active-low one-cold row strobe (registered)
//   col          active-low column inputs (asynchronous)
//   key_code     index row*COLS+col of the accepted key (held after release)
//   key_valid    high while a debounced key is held
//   key_press    one-cycle pulse on an accepted press (or auto-repeat)
//   key_release  one-cycle pulse on an accepted release
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_TICKS   = 12500,
    parameter int DB_FRAMES    = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ROWS-1:0]              row,
    input  logic [COLS-1:0]              col,
    output logic [$clog2(ROWS*COLS)-1:0] key_code,
    output logic                         key_valid,
    output logic                         key_press,
    output logic                         key_release
);

    localparam int CODE_W = $clog2(ROWS*COLS);
    localparam int TICK_W = $clog2(SCAN_TICKS);
    localparam int RIDX_W = $clog2(ROWS);
    localparam int CNT_W  = $clog2(DB_FRAMES + 1);

    // SWAP is the one-cycle gap between the release and press of a key change
    typedef enum logic [1:0] {IDLE, HELD, SWAP} state_t;

    logic [TICK_W-1:0] tick;
    logic [RIDX_W-1:0] row_idx;
    logic [COLS-1:0]   col_meta;
    logic [COLS-1:0]   col_sync;

    logic              acc_vld;
    logic [CODE_W-1:0] acc_code;
    logic              prev_vld;
    logic [CODE_W-1:0] prev_code;
    logic [CNT_W-1:0]  db_cnt;

    state_t            state;
    state_t            state_next;
    logic [CODE_W-1:0] pend_code;
    logic [CODE_W-1:0] pend_next;
    logic [CODE_W-1:0] code_next;
    logic              valid_next;
    logic              press_next;
    logic              release_next;

    logic              sample;
    logic              frame_end;
    logic              row_hit;
    logic [CODE_W-1:0] row_code;
    logic              cand_vld;
    logic [CODE_W-1:0] cand_code;
    logic              same_cand;
    logic [CNT_W-1:0]  cnt_next;
    logic              stable;
    logic              rep_fire;

    assign sample    = (tick == TICK_W'(SCAN_TICKS - 1));
    assign frame_end = sample && (row_idx == RIDX_W'(ROWS - 1));

    // Scan timing: row and row_idx move together so that row is registered.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick    <= '0;
            row_idx <= '0;
            row     <= ~ROWS'(1);
        end else if (sample) begin
            tick    <= '0;
            row     <= {row[ROWS-2:0], row[ROWS-1]};
            row_idx <= (row_idx == RIDX_W'(ROWS - 1)) ? '0 : row_idx + RIDX_W'(1);
        end else begin
            tick <= tick + TICK_W'(1);
        end
    end

    // Lowest pressed column in the row currently driven. The loop runs downward,
    // so the lowest column index is the last one written.
    // NOTE: every always_comb output gets a default first; otherwise paths
    // that skip an assignment infer latches.
    always_comb begin
        row_hit  = 1'b0;
        row_code = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_sync[c]) begin
                row_hit  = 1'b1;
                row_code = CODE_W'(int'(row_idx) * COLS + c);
            end
        end
    end

    // The frame candidate keeps the first hit of the frame. Rows are scanned in
    // ascending order, so the first hit is the lowest row-major index.
    assign cand_vld  = acc_vld | row_hit;
    assign cand_code = acc_vld ? acc_code : row_code;
    assign same_cand = (cand_vld == prev_vld) && (!cand_vld || (cand_code == prev_code));
    assign cnt_next  = !same_cand               ? CNT_W'(1) :
                       (db_cnt == CNT_W'(DB_FRAMES)) ? db_cnt : db_cnt + CNT_W'(1);
    // Fires once, on the frame where the run reaches DB_FRAMES. It does not
    // fire again while the counter stays saturated on the same candidate.
    assign stable    = frame_end && (cnt_next == CNT_W'(DB_FRAMES)) &&
                       !(same_cand && (db_cnt == CNT_W'(DB_FRAMES)));

    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta  <= '1;
            col_sync  <= '1;
            acc_vld   <= 1'b0;
            acc_code  <= '0;
            prev_vld  <= 1'b0;
            prev_code <= '0;
            db_cnt    <= '0;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
            if (frame_end) begin
                acc_vld   <= 1'b0;
                prev_vld  <= cand_vld;
                prev_code <= cand_code;
                db_cnt    <= cnt_next;
            end else if (sample && row_hit && !acc_vld) begin
                acc_vld  <= 1'b1;
                acc_code <= row_code;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;
    logic             holding_same;

    assign holding_same = (state == HELD) && cand_vld && (cand_code == key_code);
    // The first repeat waits REPEAT_DELAY frames after the press. Later repeats
    // wait REPEAT_RATE frames.
    assign rep_fire = frame_end && holding_same &&
                      ((rep_cnt + REP_W'(1)) ==
                       (rep_armed ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY)));

    always_ff @(posedge clk) begin
        if (rst || (state != HELD)) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (frame_end) begin
            if (!holding_same) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Next-state and next-output logic. All outputs are registered, so the
    // pulses appear in the cycle after the closing sample of a frame.
    always_comb begin
        state_next   = state;
        code_next    = key_code;
        valid_next   = key_valid;
        press_next   = 1'b0;
        release_next = 1'b0;
        pend_next    = pend_code;
        case (state)
            IDLE: begin
                if (stable && cand_vld) begin
                    code_next  = cand_code;
                    valid_next = 1'b1;
                    press_next = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (stable && !cand_vld) begin
                    release_next = 1'b1;
                    valid_next   = 1'b0;
                    state_next   = IDLE;
                end else if (stable && (cand_code != key_code)) begin
                    release_next = 1'b1;
                    pend_next    = cand_code;
                    state_next   = SWAP;
                end else if (rep_fire) begin
                    press_next = 1'b1;
                end
            end
            SWAP: begin
                code_next  = pend_code;
                press_next = 1'b1;
                state_next = HELD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            pend_code   <= '0;
        end else begin
            state       <= state_next;
            key_code    <= code_next;
            key_valid   <= valid_next;
            key_press   <= press_next;
            key_release <= release_next;
            pend_code   <= pend_next;
        end
    end

endmodule
